// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths and helpers for the pending-write scoreboard.
// Consumed by hazard_pend_ctr and hazard_scoreboard.
package hazard_pkg;

  localparam int DEF_REG_W  = 4;
  localparam int DEF_PEND_W = 2;
  localparam int NUM_REGS   = 1 << DEF_REG_W;

  function automatic int max_pend(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/hazard_pend_ctr.sv
// hazard_pend_ctr: one register's outstanding-write counter.
// Up/down, saturating at both ends, with under/overflow strobes.
module hazard_pend_ctr
  import hazard_pkg::*;
#(
  parameter int W = DEF_PEND_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic max,
  output logic underflow,
  output logic overflow
);

  localparam logic [W-1:0] MAX_CNT = W'(max_pend(W));

  logic [W-1:0] cnt;

  assign zero      = (cnt == '0);
  assign max       = (cnt == MAX_CNT);
  assign underflow = dec & zero;
  assign overflow  = inc & ~dec & max;

  // count issues up and retires down; simultaneous inc/dec cancel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc & ~dec & ~max) begin
      cnt <= cnt + 1'b1;
    end else if (dec & ~inc & ~zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write RAW/load-use stall logic.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W        = DEF_REG_W,
  parameter int PEND_W       = DEF_PEND_W,
  parameter bit RF_WB_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             id_valid,
  input  logic             id_wb_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             flush,
  input  logic             forward_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wb_en,
  input  logic             mem_ready,
  output logic             hazard,
  output logic             freeze,
  output logic             pend_err,
  output logic             busy_any
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      freeze_cycles,
  output logic [31:0]      loaduse_cycles
`endif
);

  localparam int NR = 1 << REG_W;

  logic [NR-1:0] inc_v;
  logic [NR-1:0] dec_v;
  logic [NR-1:0] zero_v;
  logic [NR-1:0] max_v;
  logic [NR-1:0] uf_v;
  logic [NR-1:0] of_v;

  logic issue;
  logic retire;
  logic busy1;
  logic busy2;
  logic raw;
  logic load_use;
  logic sat;

  assign freeze = ~mem_ready;
  assign retire = wb_wb_en & ~freeze;

  // a register retiring this cycle is readable when the RF bypasses
  assign busy1 = ~zero_v[src1]
               & ~(RF_WB_BYPASS & retire & (wb_dest == src1));
  assign busy2 = ~zero_v[src2]
               & ~(RF_WB_BYPASS & retire & (wb_dest == src2));

  assign raw = busy1 | (two_src & busy2);

  assign load_use = exe_wb_en & exe_mem_r_en
                  & ((src1 == exe_dest)
                  | (two_src & (src2 == exe_dest)));

  assign sat = id_valid & id_wb_en & max_v[id_dest];

  assign hazard = (forward_en ? load_use : raw) | sat;

  assign issue = id_valid & id_wb_en & ~hazard & ~freeze & ~flush;

  assign busy_any = ~&zero_v;

  for (genvar i = 0; i < NR; i++) begin : g_ctr
    assign inc_v[i] = issue  & (id_dest == REG_W'(i));
    assign dec_v[i] = retire & (wb_dest == REG_W'(i));

    hazard_pend_ctr #(
      .W (PEND_W)
    ) u_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_v[i]),
      .dec       (dec_v[i]),
      .zero      (zero_v[i]),
      .max       (max_v[i]),
      .underflow (uf_v[i]),
      .overflow  (of_v[i])
    );
  end

  // sticky error on any counter under/overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_err <= 1'b0;
    end else if ((|uf_v) | (|of_v)) begin
      pend_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // saturating stall/freeze/load-use cycle counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      freeze_cycles  <= '0;
      loaduse_cycles <= '0;
    end else begin
      if (hazard && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (freeze && freeze_cycles != '1)
        freeze_cycles <= freeze_cycles + 1'b1;
      if (forward_en && load_use && loaduse_cycles != '1)
        loaduse_cycles <= loaduse_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus with queued expectations.
// A negedge monitor pops and compares against the DUT outputs.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic [3:0] src1;
  logic [3:0] src2;
  logic       two_src;
  logic       id_valid;
  logic       id_wb_en;
  logic [3:0] id_dest;
  logic       flush;
  logic       forward_en;
  logic [3:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_r_en;
  logic [3:0] wb_dest;
  logic       wb_wb_en;
  logic       mem_ready;
  logic       hazard;
  logic       freeze;
  logic       pend_err;
  logic       busy_any;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] freeze_cycles;
  logic [31:0] loaduse_cycles;
`endif

  hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .id_valid     (id_valid),
    .id_wb_en     (id_wb_en),
    .id_dest      (id_dest),
    .flush        (flush),
    .forward_en   (forward_en),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .wb_dest      (wb_dest),
    .wb_wb_en     (wb_wb_en),
    .mem_ready    (mem_ready),
    .hazard       (hazard),
    .freeze       (freeze),
    .pend_err     (pend_err),
    .busy_any     (busy_any)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .freeze_cycles  (freeze_cycles),
    .loaduse_cycles (loaduse_cycles)
`endif
  );

  typedef struct {
    string nm;
    logic  h;
    logic  f;
    logic  b;
    logic  e;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld,
                     input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0b want=%0b", nm, fld, got, want);
    end
  endtask

  // monitor: compare everything queued during the last high phase
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "hazard",   hazard,   e.h);
      chk(e.nm, "freeze",   freeze,   e.f);
      chk(e.nm, "busy_any", busy_any, e.b);
      chk(e.nm, "pend_err", pend_err, e.e);
    end
  end

  task automatic expect_o(input string nm, input logic h, input logic f,
                          input logic b, input logic e);
    exp_t x;
    x.nm = nm;
    x.h  = h;
    x.f  = f;
    x.b  = b;
    x.e  = e;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src1 = 0; src2 = 0; two_src = 0;
    id_valid = 0; id_wb_en = 0; id_dest = 0;
    flush = 0; forward_en = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    wb_dest = 0; wb_wb_en = 0; mem_ready = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 0;
    cyc();
    cyc();
    expect_o("rst", 0, 0, 0, 0);
    cyc();
    rst_n = 1;

    // RAW on R3 without forwarding
    id_valid = 1; id_wb_en = 1; id_dest = 3;
    expect_o("iss3", 0, 0, 0, 0);
    cyc();
    id_wb_en = 0; src1 = 3;
    expect_o("raw3", 1, 0, 1, 0);
    cyc();
    src1 = 0; src2 = 3; two_src = 0;
    expect_o("s2_one", 0, 0, 1, 0);
    cyc();
    two_src = 1;
    expect_o("raw3_s2", 1, 0, 1, 0);
    cyc();
    two_src = 0; src2 = 0; src1 = 3;
    wb_wb_en = 1; wb_dest = 3;
    expect_o("byp3", 0, 0, 1, 0);
    cyc();
    wb_wb_en = 0;
    expect_o("ret3", 0, 0, 0, 0);
    cyc();

    // load-use with forwarding
    src1 = 0; forward_en = 1;
    exe_dest = 5; exe_wb_en = 1; exe_mem_r_en = 1;
    src2 = 5; two_src = 1;
    expect_o("lu_s2", 1, 0, 0, 0);
    cyc();
    two_src = 0;
    expect_o("lu_one", 0, 0, 0, 0);
    cyc();
    src1 = 5;
    expect_o("lu_s1", 1, 0, 0, 0);
    cyc();
    exe_mem_r_en = 0;
    expect_o("no_load", 0, 0, 0, 0);
    cyc();
    idle();
    id_valid = 1;

    // freeze holds a pending WB retire on R7
    id_wb_en = 1; id_dest = 7;
    expect_o("iss7", 0, 0, 0, 0);
    cyc();
    id_wb_en = 0; src1 = 7;
    mem_ready = 0; wb_wb_en = 1; wb_dest = 7;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        id_wb_en = 1; id_dest = 8; src1 = 0;
        expect_o("frz_iss", 0, 1, 1, 0);
      end else begin
        expect_o("frz", 1, 1, 1, 0);
      end
      cyc();
    end
    id_wb_en = 0; src1 = 7; mem_ready = 1;
    expect_o("unfrz", 0, 0, 1, 0);
    cyc();
    wb_wb_en = 0;
    expect_o("dec7", 0, 0, 0, 0);
    cyc();

    // saturation and simultaneous issue/retire on R2
    src1 = 0; id_wb_en = 1; id_dest = 2;
    expect_o("sat_i1", 0, 0, 0, 0);
    cyc();
    expect_o("sat_i2", 0, 0, 1, 0);
    cyc();
    expect_o("sat_i3", 0, 0, 1, 0);
    cyc();
    expect_o("sat_h", 1, 0, 1, 0);
    cyc();
    forward_en = 1;
    expect_o("sat_fwd", 1, 0, 1, 0);
    cyc();
    forward_en = 0; id_wb_en = 0;
    wb_wb_en = 1; wb_dest = 2;
    expect_o("r2_ret", 0, 0, 1, 0);
    cyc();
    id_wb_en = 1;
    expect_o("r2_both", 0, 0, 1, 0);
    cyc();
    wb_wb_en = 0;
    expect_o("r2_post", 0, 0, 1, 0);
    cyc();
    expect_o("r2_resat", 1, 0, 1, 0);
    cyc();
    id_wb_en = 0; wb_wb_en = 1;
    repeat (3) cyc();
    wb_wb_en = 0;
    expect_o("r2_drain", 0, 0, 0, 0);
    cyc();

    // underflow on R9
    wb_wb_en = 1; wb_dest = 9;
    expect_o("uf_pre", 0, 0, 0, 0);
    cyc();
    wb_wb_en = 0;
    expect_o("uf_set", 0, 0, 0, 1);
    cyc();
    expect_o("uf_hold", 0, 0, 0, 1);
    cyc();
    rst_n = 0; mem_ready = 0;
    cyc();
    expect_o("uf_rst", 0, 1, 0, 0);
    cyc();

    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
